// File: rtl/load_store_unit.sv
// RV64 load/store front end for a word-addressed, byte-enable-less data memory.
// Splits byte addresses, extends loads, and read-modify-writes sub-doubleword stores.
module load_store_unit #(
  parameter int BITS       = 64,
  parameter int DEPTH      = 32,
  parameter int WADDR_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [BITS-1:0]       req_addr,
  input  logic [BITS-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [BITS-1:0]       resp_rdata,
  output logic                  resp_misaligned,
  output logic [WADDR_BITS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [BITS-1:0]       mem_din,
  input  logic [BITS-1:0]       mem_dout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } state_e;

  state_e                state_q;
  logic [2:0]            funct3_q;
  logic [2:0]            off_q;
  logic [BITS-1:0]       wdata_q;
  logic                  resp_valid_q;
  logic                  resp_misaligned_q;
  logic [BITS-1:0]       resp_rdata_q;
  logic                  mem_we_q;
  logic [BITS-1:0]       mem_din_q;
  logic [WADDR_BITS-1:0] mem_addr_q;

  // Byte address bits above the word index are deliberately dropped (addresses wrap).
  logic addr_unused;
  assign addr_unused = ^req_addr[BITS-1:WADDR_BITS+3];

  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [2:0] off);
    case (f3)
      3'b000:  is_fault = 1'b0;
      3'b001:  is_fault = off[0];
      3'b010:  is_fault = |off[1:0];
      3'b011:  is_fault = |off;
      3'b100:  is_fault = we;
      3'b101:  is_fault = we | off[0];
      3'b110:  is_fault = we | (|off[1:0]);
      default: is_fault = 1'b1;
    endcase
  endfunction

  logic [5:0]      shamt;
  logic [BITS-1:0] field;
  logic [BITS-1:0] size_mask;
  logic [BITS-1:0] lane_mask;
  logic [BITS-1:0] load_val_d;
  logic [BITS-1:0] merged_d;
  logic            req_fault;

  assign shamt     = {off_q, 3'b000};
  assign field     = mem_dout >> shamt;
  assign lane_mask = size_mask << shamt;
  assign merged_d  = (mem_dout & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  assign req_fault = is_fault(req_we, req_funct3, req_addr[2:0]);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    size_mask  = '1;
    load_val_d = field;
    case (funct3_q[1:0])
      2'b00: begin
        size_mask  = {{(BITS-8){1'b0}}, 8'hFF};
        load_val_d = funct3_q[2] ? {{(BITS-8){1'b0}}, field[7:0]}
                                 : {{(BITS-8){field[7]}}, field[7:0]};
      end
      2'b01: begin
        size_mask  = {{(BITS-16){1'b0}}, 16'hFFFF};
        load_val_d = funct3_q[2] ? {{(BITS-16){1'b0}}, field[15:0]}
                                 : {{(BITS-16){field[15]}}, field[15:0]};
      end
      2'b10: begin
        size_mask  = {{(BITS-32){1'b0}}, 32'hFFFF_FFFF};
        load_val_d = funct3_q[2] ? {{(BITS-32){1'b0}}, field[31:0]}
                                 : {{(BITS-32){field[31]}}, field[31:0]};
      end
      default: begin
        size_mask  = '1;
        load_val_d = field;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      funct3_q          <= '0;
      off_q             <= '0;
      wdata_q           <= '0;
      resp_valid_q      <= 1'b0;
      resp_misaligned_q <= 1'b0;
      resp_rdata_q      <= '0;
      mem_we_q          <= 1'b0;
      mem_din_q         <= '0;
      mem_addr_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            off_q      <= req_addr[2:0];
            wdata_q    <= req_wdata;
            mem_addr_q <= req_addr[WADDR_BITS+2:3];
            if (req_fault) begin
              resp_valid_q      <= 1'b1;
              resp_misaligned_q <= 1'b1;
              resp_rdata_q      <= '0;
              state_q           <= RESP;
            end else if (!req_we) begin
              state_q <= LOAD;
            end else if (req_funct3 == 3'b011) begin
              mem_we_q  <= 1'b1;
              mem_din_q <= req_wdata;
              state_q   <= WRITE;
            end else begin
              state_q <= MERGE;
            end
          end
        end
        LOAD: begin
          resp_rdata_q      <= load_val_d;
          resp_valid_q      <= 1'b1;
          resp_misaligned_q <= 1'b0;
          state_q           <= RESP;
        end
        MERGE: begin
          mem_din_q <= merged_d;
          mem_we_q  <= 1'b1;
          state_q   <= WRITE;
        end
        WRITE: begin
          mem_we_q          <= 1'b0;
          resp_rdata_q      <= '0;
          resp_valid_q      <= 1'b1;
          resp_misaligned_q <= 1'b0;
          state_q           <= RESP;
        end
        RESP: begin
          resp_valid_q      <= 1'b0;
          resp_misaligned_q <= 1'b0;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_rdata      = resp_rdata_q;
  assign mem_addr        = mem_addr_q;
  assign mem_din         = mem_din_q;
  // Reset asserted during WRITE must suppress the write that would land on that same edge.
  assign mem_we          = mem_we_q & ~reset;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Byte-addressed RV64 load/store front end placed directly upstream of the data memory (64-bit words, DEPTH entries, word-addressed, combinational read, write on posedge clk with a single whole-word write enable).
Accepts one request at a time from the execute stage and splits the byte address into a word index plus a byte offset.
Loads: extracts the addressed field and sign- or zero-extends it.
Sub-doubleword stores: performs a read-modify-write, because the memory has no byte enables.

Parameters:
BITS, 64, data word width (fixed at 64 for RV64; other values unsupported)
DEPTH, 32, number of memory words
WADDR_BITS, 5, word index width = log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  input  64  byte address
req_wdata  input  64  store data; low bytes are used for sub-word stores
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  64  extended load result
resp_misaligned  output  1  fault flag, valid with resp_valid
mem_addr  output  WADDR_BITS  word index to memory
mem_we  output  1  memory write enable
mem_din  output  64  memory write data
mem_dout  input  64  memory read data (combinational)

Behaviour:
- Reset (on a posedge clk with reset=1):
  - state goes to IDLE;
  - resp_valid=0, resp_misaligned=0, resp_rdata=0, mem_we=0, mem_din=0, mem_addr=0;
  - all latched request registers are cleared.
- Reset wins over everything. Reset asserted in any state aborts the operation, and no mem_we pulse may follow it.
- Accept: a request is accepted on a posedge with req_valid=1 and state IDLE. At that edge, latch req_we, req_funct3, req_addr and req_wdata. Inputs are ignored in every other state.
- Address split:
  - word index = addr[WADDR_BITS+2:3];
  - offset = addr[2:0];
  - addr bits above WADDR_BITS+2 are ignored, so addresses wrap modulo DEPTH*8 bytes.
- Fault check, evaluated at accept:
  - H/HU with offset[0]≠0 → fault;
  - W/WU with offset[1:0]≠0 → fault;
  - D with offset≠0 → fault;
  - funct3=111 → fault;
  - store with funct3 of BU/HU/WU → fault.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
  - IDLE: req_ready=1. On accept, go to RESP if fault; otherwise LOAD for a load, WRITE for an SD, MERGE for SB/SH/SW.
  - LOAD: mem_addr = word index. Register the extracted field of mem_dout into resp_rdata:
    - B/H/W are sign-extended from bit 7/15/31;
    - BU/HU/WU are zero-extended;
    - D is passed through.
    - Then go to RESP.
  - MERGE: mem_addr = word index. Register the merged word: mem_dout with bytes [offset .. offset+size-1] replaced by the low size bytes of the latched wdata. Then go to WRITE.
  - WRITE: mem_addr = word index, mem_we=1 for exactly this cycle. mem_din = merged word, or the latched wdata for SD. Go to RESP.
  - RESP: resp_valid=1 for one cycle, resp_misaligned=fault, req_ready=0. Go to IDLE.
- resp_rdata:
  - updated only on load completion;
  - set to 0 for stores and faults;
  - otherwise holds its value between responses.
- mem_we=0 in all states except WRITE. A faulting request never writes memory.
- Latency from the accept edge to resp_valid high:
  - fault: 1 cycle;
  - load: 2 cycles;
  - SD: 2 cycles;
  - SB/SH/SW: 3 cycles.
- Throughput: back-to-back requests are possible. The next accept happens in the IDLE cycle after RESP.

Test Plan:
- Memory preloaded word0=48, word1=20. LD addr 0 → resp_rdata=48 two cycles after accept. LW addr 8 → 20. Neither pulses mem_we.
- SB wdata=0xFF addr 9 → one mem_we pulse, mem_addr=1, mem_din=0xFF14, resp 3 cycles after accept. Then LD addr 8 → 0xFF14.
- After the SB above: LB addr 9 → 0xFFFFFFFFFFFFFFFF; LBU addr 9 → 0xFF; LH addr 8 → 0xFFFFFFFFFFFFFF14; LHU addr 8 → 0xFF14.
- LW addr 2, SD addr 4, and funct3=111 → resp_misaligned=1 one cycle after accept, resp_rdata=0, mem_we never asserted, memory contents unchanged.
- SD 0x0123456789ABCDEF at addr 0x100 (wraps to word 0) → LD addr 0 returns 0x0123456789ABCDEF. LWU addr 4 → 0x01234567.
- Assert reset during the MERGE state of an SH → no mem_we pulse, resp_valid stays 0, req_ready=1 in the first cycle after reset deasserts, and memory is unchanged.
